// File: rtl/alu_ctrl.sv
// Multi-cycle execute controller for the 16-bit ALU: accepts one instruction per handshake,
// sequences DECODE/EXEC/WB around an external combinational ALU and owns the register file and flags.
module alu_ctrl #(
  parameter int NREGS = 8,
  parameter int IMM_W = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] instr,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [2:0]  alu_code,
  input  logic [15:0] alu_out,
  input  logic        alu_carry,
  input  logic        alu_zero,
  output logic        done,
  output logic [15:0] result,
  output logic        carry_flag,
  output logic        zero_flag,
  input  logic [2:0]  dbg_addr,
  output logic [15:0] dbg_data
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_WB     = 2'd3
  } state_t;

  state_t      state_r;
  state_t      next_state_s;
  logic        ready_r;
  logic [15:0] instr_r;
  logic [15:0] regs_r [NREGS];
  logic [15:0] alu_a_r;
  logic [15:0] alu_b_r;
  logic [2:0]  alu_code_r;
  logic [15:0] hold_out_r;
  logic        hold_carry_r;
  logic        hold_zero_r;
  logic        done_r;
  logic [15:0] result_r;
  logic        carry_r;
  logic        zero_r;

  logic        accept_s;
  logic [2:0]  code_s;
  logic [2:0]  rd_s;
  logic [2:0]  rs_s;
  logic [2:0]  rt_s;
  logic        imm_sel_s;
  logic [15:0] imm_ext_s;
  logic [15:0] rs_val_s;
  logic [15:0] rt_val_s;

  assign accept_s  = instr_valid && ready_r;
  assign code_s    = instr_r[15:13];
  assign rd_s      = instr_r[12:10];
  assign rs_s      = instr_r[9:7];
  assign imm_sel_s = instr_r[6];
  assign rt_s      = instr_r[5:3];
  assign imm_ext_s = {{(16 - IMM_W){1'b0}}, instr_r[IMM_W-1:0]};

  // r0 is never written, but reads are forced to zero so the array entry is irrelevant
  assign rs_val_s = (rs_s == 3'd0) ? 16'h0000 : regs_r[rs_s];
  assign rt_val_s = (rt_s == 3'd0) ? 16'h0000 : regs_r[rt_s];
  assign dbg_data = (dbg_addr == 3'd0) ? 16'h0000 : regs_r[dbg_addr];

  assign instr_ready = ready_r;
  assign alu_a       = alu_a_r;
  assign alu_b       = alu_b_r;
  assign alu_code    = alu_code_r;
  assign done        = done_r;
  assign result      = result_r;
  assign carry_flag  = carry_r;
  assign zero_flag   = zero_r;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state sequencing
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          next_state_s = S_DECODE;
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_DECODE: next_state_s = S_EXEC;
      S_EXEC:   next_state_s = S_WB;
      S_WB:     next_state_s = S_IDLE;
      default:  next_state_s = S_IDLE;
    endcase
  end

  // Ready is registered so it is low throughout reset and rises on the first edge after it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_r <= 1'b0;
    end else begin
      ready_r <= (next_state_s == S_IDLE);
    end
  end

  // Instruction latch on accept; held until the next accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_r <= 16'h0000;
    end else if (accept_s) begin
      instr_r <= instr;
    end
  end

  // ALU operand/code registers loaded in DECODE, held otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a_r    <= 16'h0000;
      alu_b_r    <= 16'h0000;
      alu_code_r <= 3'b000;
    end else if (state_r == S_DECODE) begin
      alu_a_r    <= rs_val_s;
      alu_b_r    <= imm_sel_s ? imm_ext_s : rt_val_s;
      alu_code_r <= code_s;
    end
  end

  // Capture ALU response in EXEC
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_out_r   <= 16'h0000;
      hold_carry_r <= 1'b0;
      hold_zero_r  <= 1'b0;
    end else if (state_r == S_EXEC) begin
      hold_out_r   <= alu_out;
      hold_carry_r <= alu_carry;
      hold_zero_r  <= alu_zero;
    end
  end

  // Writeback: register file, result, flags and the done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= 16'h0000;
      end
      result_r <= 16'h0000;
      carry_r  <= 1'b0;
      zero_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      done_r <= (state_r == S_WB);
      if (state_r == S_WB) begin
        if (rd_s != 3'd0) begin
          regs_r[rd_s] <= hold_out_r;
        end
        result_r <= hold_out_r;
        zero_r   <= hold_zero_r;
        // Only ADD defines a carry; every other op leaves the flag alone
        if (code_s == 3'b000) begin
          carry_r <= hold_carry_r;
        end
      end
    end
  end

endmodule
